// File: rtl/cpu10_pkg.sv
// Shared constants and loader state encoding for the 10-bit CPU and its
// instruction memory loader.
package cpu10_pkg;

  localparam int CPU_DATA_W = 10;
  localparam int CPU_ADDR_W = 10;
  localparam int IMEM_DEPTH = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } loader_state_t;

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: one synchronous write port, one asynchronous read port
// so the CPU sees the same zero-latency timing as a ROM.
module imem_ram #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 128,
  parameter int AW     = 7
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read sees the pre-edge contents, so a same-cycle write returns old data.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/imem_loader.sv
// Streams a program into instruction memory from address 0 and holds the CPU
// in reset until a complete program (in_last seen) has been stored.
module imem_loader
  import cpu10_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] read_data,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W-1:0] word_count,
  output logic [DATA_W-1:0] checksum
);

  localparam int RAM_AW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  loader_state_t     state_reg, state_next;
  logic [ADDR_W-1:0] count_reg, count_next;
  logic [DATA_W-1:0] sum_reg, sum_next;
  logic              wr_en;
  logic              accept;
  logic [DATA_W-1:0] ram_rd_data;

  assign in_ready = (state_reg == ST_LOAD) && !load_start;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    sum_next   = sum_reg;
    wr_en      = 1'b0;
    if (load_start) begin
      // A restart wins over any word offered in the same cycle.
      state_next = ST_LOAD;
      count_next = '0;
      sum_next   = '0;
    end else if (accept) begin
      if (count_reg < DEPTH_A) begin
        wr_en      = 1'b1;
        count_next = count_reg + ADDR_W'(1);
        sum_next   = sum_reg + in_data;
        if (in_last) begin
          state_next = ST_DONE;
        end
      end else begin
        // Overflow word is consumed but not stored or counted.
        state_next = ST_ERROR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      sum_reg   <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      sum_reg   <= sum_next;
    end
  end

  assign cpu_rst    = (state_reg != ST_DONE);
  assign load_done  = (state_reg == ST_DONE);
  assign load_err   = (state_reg == ST_ERROR);
  assign word_count = count_reg;
  assign checksum   = sum_reg;

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (count_reg[RAM_AW-1:0]),
    .wr_data (in_data),
    .rd_addr (address[RAM_AW-1:0]),
    .rd_data (ram_rd_data)
  );

  assign read_data = (address < DEPTH_A) ? ram_rd_data : '0;

endmodule
